truth_table_sweep_ctrl: RTL and testbench

TRUTH_TABLE_SWEEP_CTRL -- requirements
Module: truth_table_sweep_ctrl

---
 rtl/truth_table_sweep_ctrl.sv | 163 ++++++++++++++++
 tb/tb_truth_table_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweep_ctrl.sv
// Purpose: sweeps all 2^IN_W input vectors into DDNF/DKNF implementations and compares both against an expected-output ROM.
// Latency: SETTLE_CYCLES+2 cycles per vector (APPLY, WAIT x SETTLE_CYCLES, CHECK); o_done one cycle after the final CHECK.
// Backpressure: none; i_start is honoured only in IDLE, i_abort returns any active state to IDLE on the next edge.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   i_start, i_abort        sweep request / sweep termination
//   o_x, o_rom_addr         current vector to implementations and expected-table address (identical)
//   i_rom_data              expected outputs, one cycle behind o_rom_addr
//   i_y_ddnf, i_y_dknf      outputs of the two implementations under test
//   o_busy, o_done, o_pass  status: active sweep, completion pulse, last sweep result
//   o_err_count             saturating count of failing vectors
//   o_ddnf_fail/o_dknf_fail sticky per-implementation mismatch flags
//   o_first_err_addr        first failing vector, qualified by o_err_valid
module truth_table_sweep_ctrl #(
  parameter int IN_W          = 13,
  parameter int OUT_W         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [IN_W-1:0]  o_x,
  output logic [IN_W-1:0]  o_rom_addr,
  input  logic [OUT_W-1:0] i_rom_data,
  input  logic [OUT_W-1:0] i_y_ddnf,
  input  logic [OUT_W-1:0] i_y_dknf,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_err_count,
  output logic             o_ddnf_fail,
  output logic             o_dknf_fail,
  output logic [IN_W-1:0]  o_first_err_addr,
  output logic             o_err_valid
);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam logic [IN_W-1:0] LAST_ADDR   = '1;
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t          state, state_nx;
  logic [3:0]      settle, settle_nx;
  logic [IN_W-1:0] x_nx, first_nx;
  logic [15:0]     err_nx;
  logic            busy_nx, done_nx, pass_nx, ddf_nx, dkf_nx, ev_nx;
  logic            ddnf_mis, dknf_mis;

  // The address register is o_x itself; the ROM address is the same register.
  assign o_rom_addr = o_x;

  assign ddnf_mis = (i_y_ddnf != i_rom_data);
  assign dknf_mis = (i_y_dknf != i_rom_data);

  always_comb begin
    state_nx  = state;
    settle_nx = settle;
    x_nx      = o_x;
    first_nx  = o_first_err_addr;
    err_nx    = o_err_count;
    pass_nx   = o_pass;
    ddf_nx    = o_ddnf_fail;
    dkf_nx    = o_dknf_fail;
    ev_nx     = o_err_valid;
    done_nx   = 1'b0;

    case (state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          state_nx = S_APPLY;
          x_nx     = '0;
          err_nx   = '0;
          ddf_nx   = 1'b0;
          dkf_nx   = 1'b0;
          ev_nx    = 1'b0;
          pass_nx  = 1'b0;
        end
      end
      S_APPLY: begin
        state_nx  = S_WAIT;
        settle_nx = SETTLE_INIT;
      end
      S_WAIT: begin
        // Leaving at count 1 gives exactly SETTLE_CYCLES cycles in WAIT.
        if (settle == 4'd1) state_nx  = S_CHECK;
        else                settle_nx = settle - 4'd1;
      end
      S_CHECK: begin
        if (ddnf_mis || dknf_mis) begin
          // One increment per failing vector, however many bits differ.
          if (o_err_count != 16'hFFFF) err_nx = o_err_count + 16'd1;
          if (ddnf_mis) ddf_nx = 1'b1;
          if (dknf_mis) dkf_nx = 1'b1;
          if (!o_err_valid) begin
            ev_nx    = 1'b1;
            first_nx = o_x;
          end
        end
        if (o_x == LAST_ADDR) begin
          state_nx = S_DONE;
          done_nx  = 1'b1;
          // Uses the updated count so the final vector is included.
          pass_nx  = (err_nx == 16'd0);
        end else begin
          state_nx = S_APPLY;
          x_nx     = o_x + 1'b1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort discards the in-flight vector's result: results hold, pass drops.
    if (i_abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      x_nx     = o_x;
      first_nx = o_first_err_addr;
      err_nx   = o_err_count;
      ddf_nx   = o_ddnf_fail;
      dkf_nx   = o_dknf_fail;
      ev_nx    = o_err_valid;
      done_nx  = 1'b0;
      pass_nx  = 1'b0;
    end

    busy_nx = (state_nx == S_APPLY) || (state_nx == S_WAIT) || (state_nx == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      settle           <= '0;
      o_x              <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err_count      <= '0;
      o_ddnf_fail      <= 1'b0;
      o_dknf_fail      <= 1'b0;
      o_first_err_addr <= '0;
      o_err_valid      <= 1'b0;
    end else begin
      state            <= state_nx;
      settle           <= settle_nx;
      o_x              <= x_nx;
      o_busy           <= busy_nx;
      o_done           <= done_nx;
      o_pass           <= pass_nx;
      o_err_count      <= err_nx;
      o_ddnf_fail      <= ddf_nx;
      o_dknf_fail      <= dkf_nx;
      o_first_err_addr <= first_nx;
      o_err_valid      <= ev_nx;
    end
  end

endmodule

// File: tb/tb_truth_table_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_truth_table_sweep_ctrl;

  localparam int IN_W  = 4;
  localparam int OUT_W = 8;
  localparam int SET   = 2;
  localparam int NVEC  = 1 << IN_W;
  localparam int SWEEP = (SET + 2) * NVEC;

  logic             clk = 1'b0;
  logic             rst_n, i_start, i_abort;
  logic [IN_W-1:0]  o_x, o_rom_addr, o_first_err_addr;
  logic [OUT_W-1:0] i_rom_data, i_y_ddnf, i_y_dknf;
  logic             o_busy, o_done, o_pass, o_ddnf_fail, o_dknf_fail, o_err_valid;
  logic [15:0]      o_err_count;

  logic [OUT_W-1:0] dd_mask [NVEC];
  logic [OUT_W-1:0] dk_mask [NVEC];

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic [3:0]  first;
    logic        ev, ddf, dkf, pass;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   dones = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  truth_table_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .o_x(o_x), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .i_y_ddnf(i_y_ddnf), .i_y_dknf(i_y_dknf),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_count(o_err_count),
    .o_ddnf_fail(o_ddnf_fail), .o_dknf_fail(o_dknf_fail),
    .o_first_err_addr(o_first_err_addr), .o_err_valid(o_err_valid)
  );

  function automatic logic [OUT_W-1:0] rom_f(logic [IN_W-1:0] a);
    logic [OUT_W-1:0] w;
    w = {a, ~a};
    return w ^ 8'h5A;
  endfunction

  // Expected table with one-cycle read latency; implementations are combinational.
  always @(posedge clk) i_rom_data <= rom_f(o_rom_addr);
  assign i_y_ddnf = rom_f(o_x) ^ dd_mask[o_x];
  assign i_y_dknf = rom_f(o_x) ^ dk_mask[o_x];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model(input int done_cyc);
    exp_t e;
    logic dd, dk;
    e.cyc = done_cyc; e.cnt = 0; e.first = 0; e.ev = 0; e.ddf = 0; e.dkf = 0;
    for (int v = 0; v < NVEC; v++) begin
      dd = (dd_mask[v] != 0);
      dk = (dk_mask[v] != 0);
      if (dd || dk) begin
        e.cnt++;
        if (!e.ev) begin e.ev = 1'b1; e.first = 4'(v); end
      end
      e.ddf |= dd;
      e.dkf |= dk;
    end
    e.pass = (e.cnt == 0);
    return e;
  endfunction

  // Scoreboard: each o_done pulse must match the oldest expected sweep result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) chk("rom_addr_eq_x", o_rom_addr, o_x);
    if (o_done) begin
      dones++;
      if (sb.size() == 0) chk("spurious_done", o_done, 1'b0);
      else begin
        e = sb.pop_front();
        chk("done_cyc",   cyc,              e.cyc);
        chk("err_count",  o_err_count,      e.cnt);
        chk("first_addr", o_first_err_addr, e.first);
        chk("err_valid",  o_err_valid,      e.ev);
        chk("ddnf_fail",  o_ddnf_fail,      e.ddf);
        chk("dknf_fail",  o_dknf_fail,      e.dkf);
        chk("pass",       o_pass,           e.pass);
        chk("busy_done",  o_busy,           1'b0);
      end
    end
  end

  task automatic clear_masks();
    for (int v = 0; v < NVEC; v++) begin dd_mask[v] = '0; dk_mask[v] = '0; end
  endtask

  // Start sampled at the next rising edge; o_done visible SWEEP edges later.
  task automatic start_sweep(input bit expect_done);
    @(negedge clk);
    i_start = 1'b1;
    if (expect_done) sb.push_back(model(cyc + 1 + SWEEP));
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    bit seen;
    n0 = dones;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (dones > n0) seen = 1;
    end
    chk("done_timeout", seen, 1'b1);
  endtask

  task automatic wait_x(input logic [IN_W-1:0] a, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (o_x == a && o_busy) seen = 1;
    end
    chk("wait_x_timeout", seen, 1'b1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_x"},        o_x,              0);
    chk({pfx, "_rom_addr"}, o_rom_addr,       0);
    chk({pfx, "_busy"},     o_busy,           0);
    chk({pfx, "_done"},     o_done,           0);
    chk({pfx, "_pass"},     o_pass,           0);
    chk({pfx, "_cnt"},      o_err_count,      0);
    chk({pfx, "_ddf"},      o_ddnf_fail,      0);
    chk({pfx, "_dkf"},      o_dknf_fail,      0);
    chk({pfx, "_ev"},       o_err_valid,      0);
    chk({pfx, "_first"},    o_first_err_addr, 0);
  endtask

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within budget");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    clear_masks();
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Clean sweep; a second start mid-sweep must not disturb timing.
    start_sweep(1);
    repeat (10) @(negedge clk);
    chk("busy_mid", o_busy, 1'b1);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(SWEEP + 20);
    @(negedge clk);
    chk("done_one_cycle", o_done, 1'b0);
    chk("x_held_after_done", o_x, 4'hF);

    // Start and abort together in IDLE: abort wins, previous pass untouched.
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_abort_busy", o_busy, 1'b0);
    chk("idle_abort_pass", o_pass, 1'b1);

    // DKNF bit 3 wrong at vectors 5 and 9.
    clear_masks();
    dk_mask[5] = 8'h08; dk_mask[9] = 8'h08;
    start_sweep(1);
    wait_done(SWEEP + 20);

    // Both implementations wrong at vector 7 only.
    clear_masks();
    dd_mask[7] = 8'hFF; dk_mask[7] = 8'h01;
    start_sweep(1);
    wait_done(SWEEP + 20);

    // Last vector failing: must still count before pass is decided.
    clear_masks();
    dd_mask[15] = 8'h80;
    start_sweep(1);
    wait_done(SWEEP + 20);

    // Abort at address 6 with one earlier failure at vector 3.
    clear_masks();
    dd_mask[3] = 8'h10;
    start_sweep(0);
    wait_x(4'd6, 60);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_busy",  o_busy,           1'b0);
    chk("abort_pass",  o_pass,           1'b0);
    chk("abort_cnt",   o_err_count,      16'd1);
    chk("abort_ddf",   o_ddnf_fail,      1'b1);
    chk("abort_ev",    o_err_valid,      1'b1);
    chk("abort_first", o_first_err_addr, 4'd3);
    repeat (SWEEP + 10) @(negedge clk);
    chk("abort_x_held", o_x, 4'd6);

    // Reset in the middle of a failing sweep.
    clear_masks();
    dk_mask[2] = 8'h01;
    start_sweep(0);
    wait_x(4'd8, 60);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("midrst");
    repeat (SWEEP + 10) @(negedge clk);
    chk("midrst_busy", o_busy, 1'b0);

    // Recovery: clean sweep after the mid-sweep reset.
    clear_masks();
    start_sweep(1);
    wait_done(SWEEP + 20);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
